// File: rtl/cmp_stream_packer_if.sv
// Word output channel of the compare-stream packer.
// Word, popcount and parity travel together under one valid/ready pair.
interface cmp_stream_packer_if #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
);
    logic [W-1:0]  word_q;
    logic          word_vld;
    logic          word_rdy;
    logic [CW-1:0] word_ones;
    logic          word_par;

    modport master (
        output word_q,
        output word_vld,
        output word_ones,
        output word_par,
        input  word_rdy
    );

    modport slave (
        input  word_q,
        input  word_vld,
        input  word_ones,
        input  word_par,
        output word_rdy
    );
endinterface

// File: rtl/cmp_stream_packer.sv
// Packs strobed compare-result bits LSB-first into W-bit words.
// One collector word and one output word are buffered; overflow samples are counted.
module cmp_stream_packer #(
    parameter int  W  = 8,
    localparam int CW = $clog2(W + 1),
    localparam int IW = $clog2(W)
) (
    input  logic                b,
    input  logic                c,
    input  logic                sample_bit,
    input  logic                sample_stb,
    cmp_stream_packer_if.master wo,
    output logic [7:0]          drop_cnt
);
    typedef enum logic [1:0] {
        S_FILL,
        S_OUT,
        S_STALL
    } st_e;

    st_e           st_q, st_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] ones_q, ones_d;
    logic          par_q, par_d;
    logic          vld_q, vld_d;
    logic [7:0]    drop_q, drop_d;

    logic          accept, last, cmpl, pop;
    logic          load_new, load_sh, clr_vld, drop_inc;
    logic [W-1:0]  sh_nxt;

    function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    assign last = (idx_q == IW'(W - 1));
    assign pop  = vld_q && wo.word_rdy;

    // State register
    always_ff @(posedge b or negedge c) begin
        if (!c) st_q <= S_FILL;
        else    st_q <= st_d;
    end

    // Next-state logic
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_FILL:  if (cmpl) st_d = S_OUT;
            S_OUT: begin
                if (cmpl && !pop)      st_d = S_STALL;
                else if (pop && !cmpl) st_d = S_FILL;
            end
            S_STALL: if (pop) st_d = S_OUT;
            default: st_d = S_FILL;
        endcase
    end

    // Control decode
    always_comb begin
        accept   = sample_stb && (st_q != S_STALL);
        cmpl     = accept && last;
        load_new = 1'b0;
        load_sh  = 1'b0;
        clr_vld  = 1'b0;
        drop_inc = 1'b0;
        unique case (st_q)
            S_FILL:  load_new = cmpl;
            S_OUT: begin
                load_new = cmpl && pop;
                clr_vld  = pop && !cmpl;
            end
            S_STALL: begin
                load_sh  = pop;
                drop_inc = sample_stb;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_nxt = sh_q;
        if (accept) sh_nxt[idx_q] = sample_bit;
        sh_d  = sh_nxt;
        idx_d = idx_q;
        if (accept) idx_d = last ? '0 : idx_q + IW'(1);
        if (load_sh) idx_d = '0;

        word_d = word_q;
        if (load_new)     word_d = sh_nxt;
        else if (load_sh) word_d = sh_q;
        // Derived from word_d so the stats never lag the word
        ones_d = popcnt(word_d);
        par_d  = ^word_d;

        vld_d = vld_q;
        if (load_new || load_sh) vld_d = 1'b1;
        else if (clr_vld)        vld_d = 1'b0;

        drop_d = drop_q;
        if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge b or negedge c) begin
        if (!c) begin
            sh_q   <= '0;
            idx_q  <= '0;
            word_q <= '0;
            ones_q <= '0;
            par_q  <= 1'b0;
            vld_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            sh_q   <= sh_d;
            idx_q  <= idx_d;
            word_q <= word_d;
            ones_q <= ones_d;
            par_q  <= par_d;
            vld_q  <= vld_d;
            drop_q <= drop_d;
        end
    end

    assign wo.word_q    = word_q;
    assign wo.word_vld  = vld_q;
    assign wo.word_ones = ones_q;
    assign wo.word_par  = par_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_cmp_stream_packer.sv
// Directed bench for cmp_stream_packer (W=8).
// Table of per-cycle vectors plus hand sequences for stall and reset cases.
module tb_cmp_stream_packer;
    logic       b = 1'b0;
    logic       c;
    logic       sample_bit;
    logic       sample_stb;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cmp_stream_packer_if #(.W(8)) wif ();

    cmp_stream_packer #(.W(8)) dut (
        .b          (b),
        .c          (c),
        .sample_bit (sample_bit),
        .sample_stb (sample_stb),
        .wo         (wif),
        .drop_cnt   (drop_cnt)
    );

    always #5 b = ~b;

    typedef struct {
        logic       stb;
        logic       bt;
        logic       rdy;
        logic       vld;
        logic [7:0] q;
        logic [3:0] ones;
        logic       par;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic stb, input logic bt, input logic rdy,
                       input logic vld, input logic [7:0] q,
                       input logic [3:0] ones, input logic par);
        vec_t v;
        v = '{stb, bt, rdy, vld, q, ones, par};
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int unsigned act,
                       input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic vld,
                           input logic [7:0] q, input logic [3:0] ones,
                           input logic par, input logic [7:0] drop);
        chk({nm, ".vld"}, wif.word_vld, vld);
        chk({nm, ".q"}, wif.word_q, q);
        chk({nm, ".ones"}, wif.word_ones, ones);
        chk({nm, ".par"}, wif.word_par, par);
        chk({nm, ".drop"}, drop_cnt, drop);
    endtask

    task automatic step(input logic stb, input logic bt, input logic rdy);
        sample_stb   = stb;
        sample_bit   = bt;
        wif.word_rdy = rdy;
        @(posedge b);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p8d;
        logic [7:0] p02;
        logic [7:0] pat;

        c            = 1'b0;
        sample_stb   = 1'b0;
        sample_bit   = 1'b0;
        wif.word_rdy = 1'b0;
        #12;
        chk_all("reset", 0, 8'h00, 0, 0, 8'd0);
        c = 1'b1;

        // Back-to-back word, one-cycle valid, then pop+complete on one edge
        p8d = 8'h8D;
        for (int i = 0; i < 8; i++)
            add(1, p8d[i], 1, i == 7, i == 7 ? 8'h8D : 8'h00,
                i == 7 ? 4'd4 : 4'd0, 0);
        add(0, 0, 1, 0, 8'h8D, 4, 0);
        for (int i = 0; i < 8; i++)
            add(1, 1, 0, i == 7, i == 7 ? 8'hFF : 8'h8D,
                i == 7 ? 4'd8 : 4'd4, 0);
        p02 = 8'h02;
        for (int i = 0; i < 7; i++)
            add(1, p02[i], 0, 1, 8'hFF, 8, 0);
        add(1, p02[7], 1, 1, 8'h02, 1, 1);
        add(0, 0, 1, 0, 8'h02, 1, 1);

        foreach (tv[i]) begin
            step(tv[i].stb, tv[i].bt, tv[i].rdy);
            chk_all($sformatf("vec%0d", i), tv[i].vld, tv[i].q,
                    tv[i].ones, tv[i].par, 8'd0);
        end

        // Back-pressure: two full words, then four dropped samples
        for (int i = 0; i < 20; i++) step(1, 1, 0);
        chk_all("bp_stall", 1, 8'hFF, 8, 0, 8'd4);
        step(0, 0, 1);
        chk_all("bp_pop1", 1, 8'hFF, 8, 0, 8'd4);
        step(0, 0, 1);
        chk("bp_pop2.vld", wif.word_vld, 0);

        // Clean restart
        #2 c = 1'b0;
        #1 c = 1'b1;
        chk_all("reset2", 0, 8'h00, 0, 0, 8'd0);

        // Strobe during pop in STALL
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, pat[i], 0);
        chk_all("st_full", 1, 8'hFF, 8, 0, 8'd0);
        step(1, 1, 1);
        chk_all("st_pop", 1, 8'h5A, 4, 0, 8'd1);
        pat = 8'h01;
        for (int i = 0; i < 8; i++) step(1, pat[i], 0);
        step(0, 0, 1);
        chk_all("st_idx0", 1, 8'h01, 1, 1, 8'd1);

        // Saturation of the drop counter
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 1, 0);
        chk_all("sat", 1, 8'h01, 1, 1, 8'd255);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk_all("sat_hold", 1, 8'h01, 1, 1, 8'd255);

        // Async reset mid-stall, then mid-word
        #2 c = 1'b0;
        #1;
        chk_all("rst_stall", 0, 8'h00, 0, 0, 8'd0);
        #1 c = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        #2 c = 1'b0;
        #1;
        chk_all("rst_word", 0, 8'h00, 0, 0, 8'd0);
        #1 c = 1'b1;
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        chk("rst_7th.vld", wif.word_vld, 0);
        step(1, 0, 0);
        chk_all("rst_8th", 1, 8'h00, 0, 0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_stream_packer.md
# cmp_stream_packer

Downstream packer for the 1-bit compare-result stream `o` produced by the registered comparator stage. It collects strobed result bits LSB-first into W-bit words. Each finished word is presented with its popcount and parity on a valid/ready interface. A one-word collector plus a one-word output register give single-word buffering under back-pressure; samples arriving while both are full are dropped and counted.

## Interface
- W, 8, word width; legal range 2..32
- CW, $clog2(W+1), popcount width (derived, not overridden)
- b  in  1  clock; all state updates on posedge b
- c  in  1  reset, asynchronous, active-low; while low, all state and outputs are at reset values
- sample_bit  in  1  compare result bit (upstream `o`)
- sample_stb  in  1  sample_bit is valid this cycle
- word_q  out  W  packed word; bit k = k-th accepted sample of that word
- word_vld  out  1  word_q/word_ones/word_par valid
- word_rdy  in  1  consumer accepts the word on an edge where word_vld && word_rdy
- word_ones  out  CW  number of 1 bits in word_q
- word_par  out  1  XOR of word_q bits
- drop_cnt  out  8  samples dropped while stalled; saturates at 255

## Operation
- Collector: register sh[W-1:0] and index idx (0..W-1). An accepted strobe writes sh[idx] <= sample_bit, then idx++.
- The word is complete on the edge that accepts the sample with idx == W-1.
- A pop occurs on an edge where word_vld && word_rdy.
- States:
  - FILL: output register empty.
  - OUT: output valid, collector filling.
  - STALL: output valid and collector holds a complete word.
- FILL:
  - Strobes are accepted.
  - Completion: output register <= completed word (including the bit accepted this edge); word_ones/word_par are computed from it; idx <= 0; go to OUT.
- OUT:
  - Strobes are accepted.
  - Completion with a pop on the same edge: load output, stay OUT.
  - Completion without a pop: keep the word in sh, go STALL.
  - Pop without completion: word_vld <= 0, go FILL.
- STALL:
  - sample_stb is not accepted. drop_cnt <= min(drop_cnt+1, 255) per strobe.
  - A strobe on the same edge as a pop is still dropped.
  - Pop: output <= sh, idx <= 0, go OUT. word_vld stays 1.
- word_ones and word_par are registered with word_q and never lag it.
- drop_cnt is cleared only by reset.
- sample_bit is ignored when sample_stb is low.
- word_q/word_ones/word_par hold their last value when word_vld is 0.

## Timing
- Reset values: word_q=0, word_vld=0, word_ones=0, word_par=0, drop_cnt=0, idx=0, sh=0, state FILL.
- Latency: word_vld rises one cycle after the edge that accepts the W-th sample; word_q is valid in that same cycle.
- Sustained throughput: one sample per cycle, with zero drops, while word_rdy is held high.
- The consumer may hold word_rdy high continuously. word_q must not change while word_vld && !word_rdy.
- Reset assertion mid-word or mid-stall: all outputs go to reset values immediately, without waiting for a clock. Partial words are discarded.
- The first edge after reset release is a normal FILL edge.
- No combinational path from word_rdy to word_vld or word_q.

## Test plan
- Back-to-back, word_rdy=1, W=8:
  - Stimulus: strobe bits 1,0,1,1,0,0,0,1 on consecutive cycles.
  - Response: word_q=8'h8D, word_ones=4, word_par=0.
  - word_vld is high for exactly one cycle, the cycle after the 8th edge.
- Back-pressure:
  - Stimulus: word_rdy=0; 16 strobes of 1; then 4 more strobes.
  - Response: word_vld=1 with word_q=8'hFF and word_ones=8; state STALL; drop_cnt=4.
  - Then word_rdy=1 for one cycle: word_q stays 8'hFF (second word), word_vld stays 1, drop_cnt=4.
  - Next pop: word_vld=0.
- Saturation:
  - Stimulus: enter STALL, then 300 strobes with word_rdy=0.
  - Response: drop_cnt=255 and remains 255; word_q unchanged.
- Pop and complete on the same edge:
  - Stimulus: word_vld=1, word_rdy=1 on the edge accepting the 8th sample of 0,1,0,0,0,0,0,0.
  - Response: word_q=8'h02, word_ones=1, word_par=1, word_vld stays 1, drop_cnt unchanged.
- Async reset mid-word:
  - Stimulus: after 5 accepted samples, pull c low between clock edges.
  - Response: all outputs are 0 before the next edge.
  - After release, 8 strobes of 0 give word_q=8'h00, word_ones=0, word_par=0, word_vld=1 one cycle after the 8th edge.
- Strobe-during-pop in STALL:
  - Stimulus: in STALL, sample_stb=1 and word_rdy=1 on the same edge.
  - Response: drop_cnt increments by 1; the new word_q equals the collector contents; idx=0.
